alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
- Parametrised successor to the pipeline's combinational ALU.
- Keeps the single-cycle logic, compare and add/sub operations, widened to WIDTH and extended with XOR, NOR and SLTU.
- Adds an iterative multiply/divide unit that owns the HI/LO registers, using a start/busy/done handshake.
- Sits in the EX stage. The hazard unit stalls on busy and, on a flush, asserts cancel.

Parameters:
- WIDTH, 32, datapath width in bits; must be at least 4.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- srcA  in  WIDTH  operand A
- srcB  in  WIDTH  operand B
- ALUCtrl  in  4  single-cycle operation select
- start  in  1  request a mul/div operation on srcA/srcB
- md_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- cancel  in  1  abort the in-flight mul/div (pipeline flush)
- ALUResult  out  WIDTH  combinational result
- Z  out  1  high when ALUResult == 0
- busy  out  1  mul/div in progress
- done  out  1  one-cycle pulse; HI/LO updated
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Combinational path (zero latency) decodes ALUCtrl:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (both wrap modulo 2^WIDTH).
  - 0111 SLT (signed), 0101 SLTU (unsigned); result is 1 or 0 zero-extended.
  - 0011 XOR, 0100 NOR.
  - 1000 MFHI (ALUResult=hi), 1001 MFLO (ALUResult=lo).
  - Any other code gives ALUResult=0, never X.
- Z = ~|ALUResult in all modes.
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, all internal operand registers cleared. Asserting reset mid-operation discards the operation.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE: start=1 at edge E0 latches |srcA|, |srcB| (signed ops) or raw values (unsigned ops), the result-sign flags and md_op. Goes to MUL or DIV and loads counter=WIDTH.
  - MUL: shift-add, one partial product per edge, counter decrements. Goes to FIX when counter reaches 0.
  - DIV: restoring division, one quotient bit per edge. Goes to FIX when counter reaches 0.
  - FIX: applies sign correction, writes hi/lo, goes to IDLE.
- Timing:
  - Iterations occur on edges E1..E_WIDTH; FIX writes at edge E_(WIDTH+1). Latency is WIDTH+1 edges (33 for WIDTH=32).
  - busy is high from after E0 until after E_(WIDTH+1).
  - done is high for exactly the one cycle following E_(WIDTH+1), with busy=0 in that cycle.
  - A new start is accepted in the same cycle that done is high.
- Results:
  - MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product.
  - DIV/DIVU: lo = quotient, hi = remainder. Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero: same latency; lo = all ones, hi = srcA unchanged. No exception is raised.
- Signed overflow (DIV of MIN by -1): lo = MIN, hi = 0.
- start while busy is ignored; hi/lo are unaffected by it.
- cancel=1 in any non-IDLE state returns to IDLE on the next edge: busy=0, no done pulse, hi/lo keep their prior values.
- cancel takes priority over FIX.
- cancel in IDLE is ignored; cancel and start together in IDLE means start is ignored.
- MFHI/MFLO while busy return the old hi/lo. Interlocking on busy is the hazard unit's responsibility.
- Operands on srcA/srcB may change after E0 without affecting the in-flight operation.

Decomposition:
- Shared package alu_pkg:
  - ALUCtrl encodings (ALU_AND … ALU_MFLO).
  - md_op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU).
  - FSM state typedef.
- One natural sub-module: muldiv_iter (FSM, counter, shift registers, hi/lo).
- Top-level alu_muldiv holds the combinational ALU decode and instantiates muldiv_iter.

Test Plan:
- WIDTH=32, ALUCtrl=0111, srcA=0xFFFFFFFF, srcB=1 → ALUResult=1, Z=0. ALUCtrl=0101 with the same operands → ALUResult=0, Z=1.
- MULT srcA=-3 (0xFFFFFFFD), srcB=7 → done exactly 33 edges after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy low in the done cycle.
- DIV srcA=-7, srcB=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/0 → lo=0xFFFFFFFF, hi=100.
- DIV 0x80000000 by 0xFFFFFFFF → lo=0x80000000, hi=0. MULTU 0xFFFFFFFF*0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- Start MULTU 5*6, pulse cancel at edge E10 → busy=0 at E11, no done, hi/lo unchanged. Start during busy of a second op → ignored; result matches the first op only.
- Assert rst_n=0 asynchronously mid-DIV (between edges) → busy, done, hi, lo are all 0 immediately. After release, a back-to-back start issued in the done cycle is accepted.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU and its iterative multiply/divide unit.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_NOR  = 4'b0100,
    ALU_SLTU = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_MFHI = 4'b1000,
    ALU_MFLO = 4'b1001
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_FIX  = 2'b11
  } md_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider owning the HI/LO registers.
// Operates on magnitudes; the sign of each result is restored in the FIX state.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic             cancel,
  output md_state_e        state,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // Handshake: start is taken only in IDLE without cancel; the unit is busy
  // while state != IDLE; done pulses for one cycle after hi/lo are written, and
  // a new start may be issued in that same cycle.

  md_state_e        state_nxt;
  logic             load;
  logic             fix_we;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] mcand;
  logic             neg_q;
  logic             neg_r;
  logic             is_div;
  logic             div_zero;

  logic             op_signed;
  logic             op_div;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             q_bit;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  assign op_signed = (md_op == MD_MULT) || (md_op == MD_DIV);
  assign op_div    = (md_op == MD_DIV) || (md_op == MD_DIVU);
  assign a_neg     = op_signed & a[WIDTH-1];
  assign b_neg     = op_signed & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // acc:mq is the running product (multiply) or remainder:dividend (divide).
  assign mul_sum   = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : '0);
  assign div_shift = {acc, mq[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mcand};
  assign q_bit     = ~div_diff[WIDTH];

  assign prod_fix  = neg_q ? -{acc, mq} : {acc, mq};
  assign quot_fix  = div_zero ? '1 : (neg_q ? -mq : mq);
  assign rem_fix   = neg_r ? -acc : acc;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    fix_we    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !cancel) begin
          load      = 1'b1;
          state_nxt = op_div ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL, ST_DIV: begin
        if (cancel) state_nxt = ST_IDLE;
        else if (cnt == CNT_W'(1)) state_nxt = ST_FIX;
      end
      ST_FIX: begin
        if (!cancel) fix_we = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      mq       <= '0;
      mcand    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      if (load) begin
        cnt      <= CNT_W'(WIDTH);
        acc      <= '0;
        mq       <= a_mag;
        mcand    <= b_mag;
        neg_q    <= a_neg ^ b_neg;
        neg_r    <= a_neg;
        is_div   <= op_div;
        div_zero <= (b == '0);
      end else if (state == ST_MUL && !cancel) begin
        acc <= mul_sum[WIDTH:1];
        mq  <= {mul_sum[0], mq[WIDTH-1:1]};
        cnt <= cnt - CNT_W'(1);
      end else if (state == ST_DIV && !cancel) begin
        acc <= q_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        mq  <= {mq[WIDTH-2:0], q_bit};
        cnt <= cnt - CNT_W'(1);
      end
      if (fix_we) begin
        if (is_div) begin
          hi <= rem_fix;
          lo <= quot_fix;
        end else begin
          {hi, lo} <= prod_fix;
        end
      end
      done <= fix_we;
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// EX-stage ALU: zero-latency logic/compare/add-sub decode plus an iterative
// multiply/divide unit whose HI/LO registers are readable via MFHI/MFLO.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [3:0]       ALUCtrl,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic             cancel,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Z,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e md_state;
  logic      slt;
  logic      sltu;

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (srcA),
    .b      (srcB),
    .start  (start),
    .md_op  (md_op),
    .cancel (cancel),
    .state  (md_state),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  assign busy = (md_state != ST_IDLE);
  assign slt  = $signed(srcA) < $signed(srcB);
  assign sltu = srcA < srcB;

  always_comb begin
    ALUResult = '0;
    case (ALUCtrl)
      ALU_AND:  ALUResult = srcA & srcB;
      ALU_OR:   ALUResult = srcA | srcB;
      ALU_ADD:  ALUResult = srcA + srcB;
      ALU_SUB:  ALUResult = srcA - srcB;
      ALU_XOR:  ALUResult = srcA ^ srcB;
      ALU_NOR:  ALUResult = ~(srcA | srcB);
      ALU_SLT:  ALUResult = {{(WIDTH-1){1'b0}}, slt};
      ALU_SLTU: ALUResult = {{(WIDTH-1){1'b0}}, sltu};
      ALU_MFHI: ALUResult = hi;
      ALU_MFLO: ALUResult = lo;
      default:  ALUResult = '0;
    endcase
  end

  assign Z = ~|ALUResult;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed + randomized bench for alu_muldiv at WIDTH=32 against a plain-arithmetic model.
module tb_alu_muldiv;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] srcA = '0;
  logic [W-1:0] srcB = '0;
  logic [3:0]   ALUCtrl = 4'b0000;
  logic         start = 1'b0;
  logic [1:0]   md_op = 2'b00;
  logic         cancel = 1'b0;
  logic [W-1:0] ALUResult;
  logic         Z;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .srcA(srcA), .srcB(srcB), .ALUCtrl(ALUCtrl),
    .start(start), .md_op(md_op), .cancel(cancel), .ALUResult(ALUResult),
    .Z(Z), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] alu_ref(input logic [3:0] c, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint sa, sb;
    sa = {{32{a[W-1]}}, a};
    sb = {{32{b[W-1]}}, b};
    case (c)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return W'(a + b);
      4'd6:    return W'(a - b);
      4'd7:    return (sa < sb) ? 1 : 0;
      4'd5:    return (a < b) ? 1 : 0;
      4'd3:    return a ^ b;
      4'd4:    return ~(a | b);
      4'd8:    return exp_hi;
      4'd9:    return exp_lo;
      default: return '0;
    endcase
  endfunction

  task automatic md_ref(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] rh, output logic [W-1:0] rl);
    longint sa, sb;
    logic [63:0] p;
    sa = {{32{a[W-1]}}, a};
    sb = {{32{b[W-1]}}, b};
    case (op)
      2'b00: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; rh = p[63:32]; rl = p[31:0]; end
      default: begin
        if (b == 0) begin
          rl = '1; rh = a;
        end else if (op == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          rl = 32'h8000_0000; rh = '0;
        end else if (op == 2'b10) begin
          rl = W'(sa / sb); rh = W'(sa % sb);
        end else begin
          rl = a / b; rh = a % b;
        end
      end
    endcase
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 4))
      0:       return $urandom_range(0, 20);
      1:       return -$urandom_range(1, 20);
      2: begin
        case ($urandom_range(0, 4))
          0:       return '0;
          1:       return 32'h8000_0000;
          2:       return 32'h7FFF_FFFF;
          3:       return '1;
          default: return 1;
        endcase
      end
      default: return $urandom;
    endcase
  endfunction

  // Called #1 after an edge; issues start, waits for done, checks latency/result.
  // ign_at > 0 injects an extra start that many edges into the operation.
  task automatic run_md(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int ign_at, input string tag);
    logic [W-1:0] rh, rl;
    int n;
    md_ref(op, a, b, rh, rl);
    md_op = op; srcA = a; srcB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; srcA = $urandom; srcB = $urandom; ALUCtrl = ALU_MFHI;
    #1;
    check({tag, " busy_after_start"}, busy, 1);
    check({tag, " mfhi_while_busy"}, ALUResult, exp_hi);
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (i == ign_at) begin
        start = 1'b1; md_op = MD_MULT; srcA = $urandom; srcB = $urandom;
      end else begin
        start = 1'b0;
      end
      if (done) begin n = i; break; end
    end
    start = 1'b0;
    check({tag, " latency"}, n, W + 1);
    check({tag, " busy_in_done"}, busy, 0);
    check({tag, " hi"}, hi, rh);
    check({tag, " lo"}, lo, rl);
    exp_hi = rh; exp_lo = rl;
  endtask

  task automatic watch_quiet(input int edges, input string tag);
    int seen_done, seen_busy;
    seen_done = 0; seen_busy = 0;
    for (int i = 0; i < edges; i++) begin
      @(posedge clk); #1;
      if (done) seen_done++;
      if (busy) seen_busy++;
    end
    check({tag, " no_done"}, seen_done, 0);
    check({tag, " no_busy"}, seen_busy, 0);
    check({tag, " hi_kept"}, hi, exp_hi);
    check({tag, " lo_kept"}, lo, exp_lo);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst hi", hi, 0);
    check("rst lo", lo, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // signed vs unsigned compare boundary
    ALUCtrl = ALU_SLT; srcA = 32'hFFFF_FFFF; srcB = 32'd1; #1;
    check("slt result", ALUResult, 1);
    check("slt z", Z, 0);
    ALUCtrl = ALU_SLTU; #1;
    check("sltu result", ALUResult, 0);
    check("sltu z", Z, 1);

    // directed mul/div
    run_md(MD_MULT,  32'hFFFF_FFFD, 32'd7,        0, "mult_neg3x7");
    run_md(MD_DIV,   -32'd7,        32'd2,        0, "div_neg7_2");
    run_md(MD_DIVU,  32'd100,       32'd0,        0, "divu_by0");
    run_md(MD_DIV,   -32'd5,        32'd0,        0, "div_neg_by0");
    run_md(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    run_md(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");

    // random ALU ops, MFHI/MFLO see the latest product
    for (int i = 0; i < 40; i++) begin
      ALUCtrl = 4'($urandom_range(0, 15)); srcA = pick(); srcB = pick(); #1;
      check("alu_rand result", ALUResult, alu_ref(ALUCtrl, srcA, srcB));
      check("alu_rand z", Z, (alu_ref(ALUCtrl, srcA, srcB) == 0));
    end
    @(posedge clk); #1;

    // random mul/div
    for (int i = 0; i < 16; i++) begin
      run_md(2'($urandom_range(0, 3)), pick(), pick(), 0, "md_rand");
    end

    // cancel mid-operation: asserted after E10, sampled at E11
    md_op = MD_MULTU; srcA = 32'd5; srcB = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    cancel = 1'b1;
    check("cancel busy_before", busy, 1);
    @(posedge clk); #1;
    cancel = 1'b0;
    check("cancel busy_after", busy, 0);
    watch_quiet(40, "cancel");

    // start+cancel together in IDLE is ignored
    md_op = MD_DIVU; srcA = 32'd77; srcB = 32'd3; start = 1'b1; cancel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    watch_quiet(36, "start_cancel_idle");

    // start while busy is ignored
    run_md(MD_DIVU, 32'd1000, 32'd7, 5, "ignore_start");

    // asynchronous reset between edges mid-DIV
    md_op = MD_DIV; srcA = -32'd100; srcB = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst busy", busy, 0);
    check("async_rst done", done, 0);
    check("async_rst hi", hi, 0);
    check("async_rst lo", lo, 0);
    exp_hi = '0; exp_lo = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // back-to-back: second start issued in the done cycle
    run_md(MD_MULT, -32'd12345, 32'd678, 0, "b2b_first");
    check("b2b done_cycle", done, 1);
    run_md(MD_DIV, 32'd1000, -32'd33, 0, "b2b_second");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
